// File: rtl/recv_msg.sv
// UART word receiver: collects one message into an external buffer,
// ending on EOM character, buffer full or inter-byte timeout.
module recv_msg #(
  parameter int         MSG_LEN  = 26,
  parameter int         N_BITS   = 8,
  parameter int         TIMEOUT  = 1000000,
  parameter int         EOM_EN   = 1,
  parameter logic [7:0] EOM_CHAR = 8'h0A
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_recv,
  input  logic [N_BITS-1:0]            uart_tdata,
  input  logic                         uart_tvalid,
  output logic                         uart_tready,
  output logic [N_BITS-1:0]            msg_data,
  output logic                         msg_we,
  output logic [$clog2(MSG_LEN)-1:0]   msg_index,
  output logic [$clog2(MSG_LEN+1)-1:0] msg_len,
  output logic                         msg_done,
  output logic                         msg_timeout,
  output logic                         busy
);

  localparam int IW = $clog2(MSG_LEN);
  localparam int LW = $clog2(MSG_LEN + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RECV,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [LW-1:0]       idx_q;
  logic [TW-1:0]       cnt_q;
  logic [N_BITS-1:0]   data_q;
  logic [IW-1:0]       index_q;
  logic [LW-1:0]       len_q;
  logic                we_q;
  logic                to_q;

  logic accept;
  logic is_eom;
  logic is_last;
  logic to_hit;

  assign accept  = uart_tvalid & uart_tready;
  assign is_eom  = (EOM_EN != 0) &&
                   (uart_tdata == N_BITS'(EOM_CHAR));
  assign is_last = (idx_q == LW'(MSG_LEN - 1));
  assign to_hit  = (cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_recv) state_d = ARMED;
      ARMED: begin
        if (accept)
          state_d = (is_eom || is_last) ? DONE : RECV;
      end
      RECV: begin
        if (accept) begin
          if (is_eom || is_last) state_d = DONE;
        end else if (to_hit) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_tready = 1'b0;
    busy        = 1'b1;
    msg_done    = 1'b0;
    unique case (state_q)
      IDLE:        busy        = 1'b0;
      ARMED, RECV: uart_tready = 1'b1;
      DONE:        msg_done    = 1'b1;
      default:     busy        = 1'b0;
    endcase
  end

  // Datapath: write strobe, addresses, length and inter-byte timer
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      to_q <= 1'b0;
      if (state_q == IDLE) idx_q <= '0;
      if (accept) begin
        cnt_q <= '0;
        if (is_eom) begin
          len_q <= idx_q;
        end else begin
          we_q    <= 1'b1;
          data_q  <= uart_tdata;
          index_q <= idx_q[IW-1:0];
          idx_q   <= idx_q + LW'(1);
          if (is_last) len_q <= LW'(MSG_LEN);
        end
      end else if (state_q == RECV) begin
        if (to_hit) begin
          to_q  <= 1'b1;
          len_q <= idx_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + TW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign msg_data    = data_q;
  assign msg_we      = we_q;
  assign msg_index   = index_q;
  assign msg_len     = len_q;
  assign msg_timeout = to_q;

endmodule

// File: tb/tb_recv_msg.sv
// Scoreboard bench for recv_msg: two instances, EOM detection on
// (a) and off (b), both with MSG_LEN=4 and TIMEOUT=16.
module tb_recv_msg;

  logic       clk;
  logic       rst;
  logic       start_a;
  logic       start_b;
  logic [7:0] tdata;
  logic       tvalid;

  logic       a_rdy, a_we, a_done, a_to, a_busy;
  logic [7:0] a_data;
  logic [1:0] a_idx;
  logic [2:0] a_len;
  logic       b_rdy, b_we, b_done, b_to, b_busy;
  logic [7:0] b_data;
  logic [1:0] b_idx;
  logic [2:0] b_len;

  recv_msg #(.MSG_LEN(4), .N_BITS(8), .TIMEOUT(16),
             .EOM_EN(1), .EOM_CHAR(8'h0A)) u_a (
    .clk(clk), .rst(rst), .start_recv(start_a),
    .uart_tdata(tdata), .uart_tvalid(tvalid),
    .uart_tready(a_rdy), .msg_data(a_data), .msg_we(a_we),
    .msg_index(a_idx), .msg_len(a_len), .msg_done(a_done),
    .msg_timeout(a_to), .busy(a_busy)
  );

  recv_msg #(.MSG_LEN(4), .N_BITS(8), .TIMEOUT(16),
             .EOM_EN(0), .EOM_CHAR(8'h0A)) u_b (
    .clk(clk), .rst(rst), .start_recv(start_b),
    .uart_tdata(tdata), .uart_tvalid(tvalid),
    .uart_tready(b_rdy), .msg_data(b_data), .msg_we(b_we),
    .msg_index(b_idx), .msg_len(b_len), .msg_done(b_done),
    .msg_timeout(b_to), .busy(b_busy)
  );

  bit         sel;
  logic       m_rdy, m_we, m_done, m_to, m_busy;
  logic [7:0] m_data;
  logic [1:0] m_idx;
  logic [2:0] m_len;

  assign m_rdy  = sel ? b_rdy  : a_rdy;
  assign m_we   = sel ? b_we   : a_we;
  assign m_done = sel ? b_done : a_done;
  assign m_to   = sel ? b_to   : a_to;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_data = sel ? b_data : a_data;
  assign m_idx  = sel ? b_idx  : a_idx;
  assign m_len  = sel ? b_len  : a_len;

  typedef struct {
    logic [7:0] d;
    logic [1:0] i;
  } wr_t;

  typedef struct {
    bit is_to;
    int len;
    bit with_we;
  } ev_t;

  wr_t wq[$];
  ev_t eq[$];

  int n_chk;
  int n_bad;
  int cyc;
  int last_acc;
  int bidx;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_we) begin
        if (wq.size() > 0) begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_data", m_data, w.d);
          chk("wr_idx", m_idx, w.i);
        end else begin
          chk("spur_we", m_we, 0);
        end
      end
      if (m_done || m_to) begin
        if (eq.size() > 0) begin
          ev_t e;
          e = eq.pop_front();
          chk("ev_to", m_to, e.is_to);
          chk("ev_done", m_done, !e.is_to);
          chk("ev_len", m_len, e.len);
          chk("ev_we", m_we, e.with_we);
          if (m_to) chk("to_lat", cyc - last_acc, 16);
        end else begin
          chk("spur_ev", {m_done, m_to}, 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm();
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    start_b = 1'b0;
    bidx = 0;
  endtask

  task automatic send(input logic [7:0] b, input int bound,
                      output bit acc);
    bit eom_en;
    eom_en = !sel;
    acc = 1'b0;
    tdata = b;
    tvalid = 1'b1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (m_rdy) begin
        if (eom_en && b == 8'h0A) begin
          eq.push_back('{1'b0, bidx, 1'b0});
        end else begin
          wq.push_back('{b, 2'(bidx)});
          bidx++;
          if (bidx == 4) eq.push_back('{1'b0, 4, 1'b1});
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        acc = 1'b1;
        break;
      end
    end
    tvalid = 1'b0;
  endtask

  task automatic send_ok(input logic [7:0] b);
    bit acc;
    send(b, 8, acc);
    chk("accept", acc, 1);
  endtask

  initial begin
    bit acc;
    n_chk = 0;
    n_bad = 0;
    cyc = 0;
    last_acc = 0;
    bidx = 0;
    sel = 1'b0;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    tdata = '0;
    tvalid = 1'b0;
    tick(3);
    chk("rst_rdy", a_rdy, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_len", a_len, 0);
    chk("rst_we", a_we, 0);
    rst = 1'b0;
    tick(2);

    // "HI\n"
    arm();
    chk("armed_rdy", m_rdy, 1);
    send_ok(8'h48);
    send_ok(8'h49);
    send_ok(8'h0A);
    tick(4);
    chk("hi_len", m_len, 2);
    chk("hi_busy", m_busy, 0);

    // Buffer fill on the EOM-less instance, 0x0A is plain data
    sel = 1'b1;
    arm();
    send_ok(8'h0A);
    send_ok(8'h11);
    send_ok(8'h22);
    send_ok(8'h33);
    tick(2);
    chk("fill_rdy", m_rdy, 0);
    chk("fill_len", m_len, 4);
    send(8'h44, 6, acc);
    chk("fill_no5", acc, 0);
    tick(2);
    sel = 1'b0;

    // Timeout after three bytes
    arm();
    send_ok(8'h01);
    send_ok(8'h02);
    send_ok(8'h03);
    eq.push_back('{1'b1, 3, 1'b0});
    tick(30);
    chk("to_busy", m_busy, 0);
    chk("to_rdy", m_rdy, 0);
    chk("to_len", m_len, 3);

    // Long wait while armed, then immediate EOM
    arm();
    tick(40);
    chk("arm_busy", m_busy, 1);
    chk("arm_rdy", m_rdy, 1);
    send_ok(8'h0A);
    tick(3);
    chk("eom0_len", m_len, 0);

    // Reset mid-message
    arm();
    send_ok(8'hA1);
    send_ok(8'hA2);
    @(negedge clk);
    #1 rst = 1'b1;
    tick(1);
    chk("mr_rdy", a_rdy, 0);
    chk("mr_we", a_we, 0);
    chk("mr_done", a_done, 0);
    chk("mr_to", a_to, 0);
    chk("mr_busy", a_busy, 0);
    chk("mr_idx", a_idx, 0);
    chk("mr_len", a_len, 0);
    chk("mr_data", a_data, 0);
    rst = 1'b0;
    tick(25);
    chk("mr_rdy2", a_rdy, 0);

    // tvalid in IDLE, then start_recv while receiving
    tdata = 8'h55;
    tvalid = 1'b1;
    tick(10);
    tvalid = 1'b0;
    chk("idle_busy", m_busy, 0);
    arm();
    send_ok(8'h10);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    send_ok(8'h20);
    send_ok(8'h0A);
    tick(4);
    chk("rs_len", m_len, 2);

    chk("wq_left", wq.size(), 0);
    chk("eq_left", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
